// File: rtl/rule_slice_packer.sv
// Shadows every TCAM rule and turns each single-rule write into an 8-lane slice update.
// Update valid 10 cycles after accept; one update in flight. Optional readback: RULE_READBACK_EN.
module rule_slice_packer #(
  parameter int TCAM_DEPTH        = 32,
  parameter int TCAM_WIDTH        = 40,
  parameter int ADDR_WIDTH        = $clog2(TCAM_DEPTH),
  parameter int SLICEM_ADDR_WIDTH = ADDR_WIDTH - 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rule_valid,
  output logic                         rule_ready,
  input  logic [ADDR_WIDTH-1:0]        rule_addr,
  input  logic [TCAM_WIDTH-1:0]        rule_data,
  input  logic [TCAM_WIDTH-1:0]        rule_keep,
  output logic                         upd_valid,
  input  logic                         upd_ready,
  output logic [TCAM_WIDTH*8-1:0]      upd_data,
  output logic [TCAM_WIDTH*8-1:0]      upd_keep,
  output logic [SLICEM_ADDR_WIDTH-1:0] upd_slice_sel,
  output logic                         done,
  output logic                         busy
`ifdef RULE_READBACK_EN
  ,
  input  logic                         rb_req,
  input  logic [ADDR_WIDTH-1:0]        rb_addr,
  output logic                         rb_ack,
  output logic [TCAM_WIDTH-1:0]        rb_data,
  output logic [TCAM_WIDTH-1:0]        rb_keep
`endif
);

  localparam int EW = 2 * TCAM_WIDTH;
  localparam logic [ADDR_WIDTH:0] INIT_LAST   = (ADDR_WIDTH+1)'(TCAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] GATHER_LAST = (ADDR_WIDTH+1)'(8);
  localparam logic [EW-1:0] DEFAULT_ENTRY = {{TCAM_WIDTH{1'b1}}, {TCAM_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_GATHER,
    S_ISSUE,
    S_BUSY
  } state_t;

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH:0]          cnt_q, cnt_d;
  logic [SLICEM_ADDR_WIDTH-1:0] slice_q, slice_d;
  logic [TCAM_WIDTH*8-1:0]      upd_data_q, upd_keep_q;
  logic [2:0]                   cap_lane;

  logic [EW-1:0]                mem [TCAM_DEPTH];
  logic [EW-1:0]                rd_q;
  logic                         ram_we;
  logic [ADDR_WIDTH-1:0]        ram_addr;
  logic [EW-1:0]                ram_wdata;

`ifdef RULE_READBACK_EN
  logic                         rb_ack_q, rb_ack_d;
`endif

  // Shadow store: one port shared by sweep, rule write, gather and readback.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    rd_q <= mem[ram_addr];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slice_d   = slice_q;
    ram_we    = 1'b0;
    ram_addr  = rule_addr;
    ram_wdata = {rule_keep, rule_data};
`ifdef RULE_READBACK_EN
    rb_ack_d  = 1'b0;
`endif
    case (state_q)
      S_INIT: begin
        ram_we    = 1'b1;
        ram_addr  = cnt_q[ADDR_WIDTH-1:0];
        ram_wdata = DEFAULT_ENTRY;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == INIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (rule_valid) begin
          ram_we  = 1'b1;
          slice_d = rule_addr[ADDR_WIDTH-1:3];
          cnt_d   = '0;
          state_d = S_GATHER;
        end
`ifdef RULE_READBACK_EN
        else begin
          ram_addr = rb_addr;
          rb_ack_d = rb_req;
        end
`endif
      end
      S_GATHER: begin
        // Reads on counts 0..7, captures trail by one; count 8 is the last capture.
        ram_addr = {slice_q, cnt_q[2:0]};
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == GATHER_LAST) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (upd_ready) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (upd_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  assign cap_lane = cnt_q[2:0] - 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      cnt_q      <= '0;
      slice_q    <= '0;
      upd_data_q <= '0;
      upd_keep_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slice_q <= slice_d;
      if (state_q == S_GATHER && cnt_q != '0) begin
        upd_data_q[cap_lane*TCAM_WIDTH +: TCAM_WIDTH] <= rd_q[TCAM_WIDTH-1:0];
        upd_keep_q[cap_lane*TCAM_WIDTH +: TCAM_WIDTH] <= rd_q[EW-1:TCAM_WIDTH];
      end
    end
  end

  assign rule_ready    = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign upd_valid     = (state_q == S_ISSUE);
  assign done          = (state_q == S_BUSY) && upd_ready;
  assign upd_data      = upd_data_q;
  assign upd_keep      = upd_keep_q;
  assign upd_slice_sel = slice_q;

`ifdef RULE_READBACK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rb_ack_q <= 1'b0;
    end else begin
      rb_ack_q <= rb_ack_d;
    end
  end

  assign rb_ack  = rb_ack_q;
  assign rb_data = rb_ack_q ? rd_q[TCAM_WIDTH-1:0] : '0;
  assign rb_keep = rb_ack_q ? rd_q[EW-1:TCAM_WIDTH] : '0;
`endif

endmodule

// File: tb/tb_rule_slice_packer.sv
// Directed bench for rule_slice_packer: inputs driven 1 time unit after posedge, outputs sampled at negedge.
module tb_rule_slice_packer;

  localparam int W  = 40;
  localparam int AW = 5;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rule_valid = 1'b0;
  logic            rule_ready;
  logic [AW-1:0]   rule_addr = '0;
  logic [W-1:0]    rule_data = '0;
  logic [W-1:0]    rule_keep = '0;
  logic            upd_valid;
  logic            upd_ready = 1'b1;
  logic [8*W-1:0]  upd_data;
  logic [8*W-1:0]  upd_keep;
  logic [SW-1:0]   upd_slice_sel;
  logic            done;
  logic            busy;

  int errors = 0;
  int checks = 0;

  rule_slice_packer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rule_valid    (rule_valid),
    .rule_ready    (rule_ready),
    .rule_addr     (rule_addr),
    .rule_data     (rule_data),
    .rule_keep     (rule_keep),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_data      (upd_data),
    .upd_keep      (upd_keep),
    .upd_slice_sel (upd_slice_sel),
    .done          (done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits (bounded) for rule_ready, then presents one write for a single cycle.
  task automatic write_rule(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] k);
    int n = 0;
    @(posedge clk); #1;
    while (!rule_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rule_ready) begin
      checks++; errors++;
      $display("FAIL write_rule_timeout: rule_ready=%0b required=1", rule_ready);
    end
    rule_valid = 1'b1; rule_addr = a; rule_data = d; rule_keep = k;
    @(posedge clk); #1;
    rule_valid = 1'b0;
  endtask

  // Returns cycles from accept to the first cycle with upd_valid=1 (40 on timeout).
  task automatic wait_upd(output int lat);
    lat = 1;
    @(negedge clk);
    while (!upd_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      @(negedge clk);
    end
  endtask

  // Engine model: handshake, ready low for 'hold' cycles, then ready high.
  task automatic engine_ack(input int hold, output int done_cnt, output logic done_on_ret,
                            output logic vld_after_hs, output logic rr_after);
    done_cnt = 0;
    if (!upd_ready) begin
      @(posedge clk); #1; upd_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1; upd_ready = 1'b0;
    @(negedge clk); vld_after_hs = upd_valid; if (done) done_cnt++;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk); if (done) done_cnt++;
    end
    @(posedge clk); #1; upd_ready = 1'b1;
    @(negedge clk); done_on_ret = done; if (done) done_cnt++;
    @(posedge clk); #1;
    @(negedge clk); rr_after = rule_ready; if (done) done_cnt++;
  endtask

  task automatic test_reset();
    int n = 0;
    int vld_seen = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rule_ready !== 1'b0) begin errors++; $display("FAIL reset_rule_ready: got %b want 0", rule_ready); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid: got %b want 0", upd_valid); end
    checks++; if (upd_data !== '0) begin errors++; $display("FAIL reset_upd_data: got %h want 0", upd_data); end
    checks++; if (upd_keep !== {8*W{1'b1}}) begin errors++; $display("FAIL reset_upd_keep: got %h want all ones", upd_keep); end
    checks++; if (upd_slice_sel !== '0) begin errors++; $display("FAIL reset_slice_sel: got %0d want 0", upd_slice_sel); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    while (!rule_ready && n < 100) begin
      n++;
      if (upd_valid) vld_seen++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    checks++; if (n != 32) begin errors++; $display("FAIL reset_init_cycles: got %0d want 32", n); end
    checks++; if (vld_seen != 0) begin errors++; $display("FAIL reset_upd_valid_during_init: got %0d want 0", vld_seen); end
  endtask

  task automatic test_single_write();
    int lat, dc;
    logic dr, va, ra;
    logic [8*W-1:0] exp_d, exp_k;
    exp_d = '0; exp_k = '1;
    exp_d[5*W +: W] = 40'h12_3456_789A;
    upd_ready = 1'b1;
    write_rule(5'd5, 40'h12_3456_789A, {W{1'b1}});
    wait_upd(lat);
    checks++; if (lat != 10) begin errors++; $display("FAIL single_latency: got %0d want 10", lat); end
    checks++; if (upd_slice_sel !== 2'd0) begin errors++; $display("FAIL single_slice_sel: got %0d want 0", upd_slice_sel); end
    checks++; if (upd_data !== exp_d) begin errors++; $display("FAIL single_data: got %h want %h", upd_data, exp_d); end
    checks++; if (upd_keep !== exp_k) begin errors++; $display("FAIL single_keep: got %h want %h", upd_keep, exp_k); end
    engine_ack(3, dc, dr, va, ra);
    checks++; if (va !== 1'b0) begin errors++; $display("FAIL single_valid_after_hs: got %b want 0", va); end
    checks++; if (dc != 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", dc); end
  endtask

  task automatic test_handshake();
    int lat, dc;
    logic dr, va, ra;
    write_rule(5'd3, 40'h00_0000_0003, {W{1'b1}});
    wait_upd(lat);
    engine_ack(288, dc, dr, va, ra);
    checks++; if (dc != 1) begin errors++; $display("FAIL hs_done_count: got %0d want 1", dc); end
    checks++; if (dr !== 1'b1) begin errors++; $display("FAIL hs_done_on_ready_return: got %b want 1", dr); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL hs_rule_ready_after_done: got %b want 1", ra); end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    logic [8*W-1:0] exp_d, exp_k, snap_d, snap_k;
    logic [SW-1:0]  snap_s;
    exp_d = '0; exp_k = '1;
    exp_d[4*W +: W] = 40'hA5_A55A_5A01;
    exp_k[4*W +: W] = 40'hFF_0000_FFFF;
    write_rule(5'd20, 40'hA5_A55A_5A01, 40'hFF_0000_FFFF);
    upd_ready = 1'b0;
    wait_upd(lat);
    checks++; if (lat != 10) begin errors++; $display("FAIL bp_latency: got %0d want 10", lat); end
    checks++; if (upd_slice_sel !== 2'd2) begin errors++; $display("FAIL bp_slice_sel: got %0d want 2", upd_slice_sel); end
    checks++; if (upd_data !== exp_d || upd_keep !== exp_k) begin errors++; $display("FAIL bp_lanes: got %h/%h want %h/%h", upd_data, upd_keep, exp_d, exp_k); end
    snap_d = upd_data; snap_k = upd_keep; snap_s = upd_slice_sel;
    for (int i = 1; i < 50; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!upd_valid || upd_data !== snap_d || upd_keep !== snap_k || upd_slice_sel !== snap_s) bad++;
    end
    @(posedge clk); #1; upd_ready = 1'b1;
    @(negedge clk);
    if (!upd_valid) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d unstable cycles want 0", bad); end
    @(posedge clk); #1; upd_ready = 1'b0;
    @(negedge clk);
    checks++; if (upd_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_first_ready_hs: got valid=%b busy=%b want 0/1", upd_valid, busy); end
    @(posedge clk); #1; upd_ready = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", done); end
  endtask

  task automatic test_same_slice();
    int lat, dc;
    logic dr, va, ra;
    logic [8*W-1:0] exp_d, exp_k;
    exp_d = '0; exp_k = '1;
    exp_d[1*W +: W] = 40'hDE_ADBE_EF01;
    exp_k[1*W +: W] = 40'hFF_FFFF_FF00;
    write_rule(5'd9, 40'hDE_ADBE_EF01, 40'hFF_FFFF_FF00);
    wait_upd(lat);
    checks++; if (upd_data !== exp_d || upd_keep !== exp_k) begin errors++; $display("FAIL pair_first_lanes: got %h/%h want %h/%h", upd_data, upd_keep, exp_d, exp_k); end
    engine_ack(4, dc, dr, va, ra);
    exp_d[6*W +: W] = 40'h01_2345_6789;
    exp_k[6*W +: W] = 40'h0F_0F0F_0F0F;
    write_rule(5'd14, 40'h01_2345_6789, 40'h0F_0F0F_0F0F);
    wait_upd(lat);
    checks++; if (lat != 10) begin errors++; $display("FAIL pair_second_latency: got %0d want 10", lat); end
    checks++; if (upd_slice_sel !== 2'd1) begin errors++; $display("FAIL pair_slice_sel: got %0d want 1", upd_slice_sel); end
    checks++; if (upd_data !== exp_d) begin errors++; $display("FAIL pair_second_data: got %h want %h", upd_data, exp_d); end
    checks++; if (upd_keep !== exp_k) begin errors++; $display("FAIL pair_second_keep: got %h want %h", upd_keep, exp_k); end
    engine_ack(4, dc, dr, va, ra);
    checks++; if (dc != 1) begin errors++; $display("FAIL pair_done_count: got %0d want 1", dc); end
  endtask

  task automatic test_reset_mid_busy();
    int lat, dc;
    int n = 0;
    int done_seen = 0;
    logic dr, va, ra;
    logic [8*W-1:0] exp_d, exp_k;
    write_rule(5'd10, 40'hCC_CCCC_CCCC, {W{1'b1}});
    wait_upd(lat);
    @(posedge clk); #1; upd_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); if (done) done_seen++;
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b1 || upd_valid !== 1'b0) begin errors++; $display("FAIL midrst_in_busy: got busy=%b valid=%b want 1/0", busy, upd_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); if (done) done_seen++;
    checks++; if (upd_valid !== 1'b0 || rule_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL midrst_outputs: got valid=%b ready=%b busy=%b want 0/0/1", upd_valid, rule_ready, busy); end
    checks++; if (upd_data !== '0 || upd_keep !== {8*W{1'b1}}) begin errors++; $display("FAIL midrst_upd_regs: got %h/%h want 0/all ones", upd_data, upd_keep); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    while (!rule_ready && n < 100) begin
      n++;
      if (done) done_seen++;
      @(posedge clk); #1;
      if (n == 10) upd_ready = 1'b1;
      @(negedge clk);
    end
    checks++; if (n != 32) begin errors++; $display("FAIL midrst_init_cycles: got %0d want 32", n); end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL midrst_done_pulses: got %0d want 0", done_seen); end
    exp_d = '0; exp_k = '1;
    exp_d[5*W +: W] = 40'h13_1313_1313;
    exp_k[5*W +: W] = 40'hF0_F0F0_F0F0;
    write_rule(5'd13, 40'h13_1313_1313, 40'hF0_F0F0_F0F0);
    wait_upd(lat);
    checks++; if (upd_slice_sel !== 2'd1) begin errors++; $display("FAIL midrst_slice_sel: got %0d want 1", upd_slice_sel); end
    checks++; if (upd_data !== exp_d || upd_keep !== exp_k) begin errors++; $display("FAIL midrst_default_lanes: got %h/%h want %h/%h", upd_data, upd_keep, exp_d, exp_k); end
    engine_ack(2, dc, dr, va, ra);
    checks++; if (dc != 1) begin errors++; $display("FAIL midrst_final_done: got %0d want 1", dc); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_handshake();
    test_backpressure();
    test_same_slice();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
